// File: rtl/uart_rx_of_verifla_if.sv
// Receive-side signal bundle of the VeriFLA host link: serial line in, deframed byte out.
// master = receiver (uart_rx_of_verifla), slave = line driver / command decoder side.
interface uart_rx_of_verifla_if;
  logic       rx;
  logic [7:0] rec_dataH;
  logic       rec_readyH;
  logic       framing_err;
  logic       parity_err;

  modport master (
    input  rx,
    output rec_dataH,
    output rec_readyH,
    output framing_err,
    output parity_err
  );

  modport slave (
    output rx,
    input  rec_dataH,
    input  rec_readyH,
    input  framing_err,
    input  parity_err
  );
endinterface

// File: rtl/uart_rx_of_verifla.sv
// Oversampling 8N1 / 8E1 UART receiver for the VeriFLA host link.
// Define VERIFLA_RX_PARITY_EN to build the 8E1 variant with the PARITY state.
module uart_rx_of_verifla #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned HALF_DIV = BAUD_DIV >> 1
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_of_verifla_if.master   bus
);

  // Counter holds remaining cycles minus one, so a load of N expires N cycles later.
  localparam logic [15:0] BaudLoad = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HalfLoad = 16'(HALF_DIV - 1);

`ifdef VERIFLA_RX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } state_e;
`endif

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        ferr_q, ferr_d;
  logic        cnt_done;
`ifdef VERIFLA_RX_PARITY_EN
  logic        par_ok_q, par_ok_d;
  logic        perr_q, perr_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s      <= rx_meta_q;
    end
  end

  assign cnt_done = (cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef VERIFLA_RX_PARITY_EN
      par_ok_q  <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
`ifdef VERIFLA_RX_PARITY_EN
      par_ok_q  <= par_ok_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    ready_d   = ready_q;
    ferr_d    = 1'b0;
`ifdef VERIFLA_RX_PARITY_EN
    par_ok_d  = par_ok_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          cnt_d   = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rx_s) begin
          state_d = StIdle;
        end else begin
          // A validated start bit retires the previous byte's ready level.
          ready_d   = 1'b0;
          cnt_d     = BaudLoad;
          bit_cnt_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          cnt_d     = BaudLoad;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef VERIFLA_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef VERIFLA_RX_PARITY_EN
      StParity: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          par_ok_d = ~^{rx_s, shreg_q};
          cnt_d    = BaudLoad;
          state_d  = StStop;
        end
      end
`endif
      StStop: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!rx_s) begin
          ferr_d  = 1'b1;
          state_d = StWaitHigh;
        end else begin
          // Leaving at mid-stop bit lets a back-to-back start edge be caught.
          state_d = StIdle;
`ifdef VERIFLA_RX_PARITY_EN
          if (par_ok_q) begin
            data_d  = shreg_q;
            ready_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
`else
          data_d  = shreg_q;
          ready_d = 1'b1;
`endif
        end
      end
      StWaitHigh: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.rec_dataH   = data_q;
  assign bus.rec_readyH  = ready_q;
  assign bus.framing_err = ferr_q;
`ifdef VERIFLA_RX_PARITY_EN
  assign bus.parity_err  = perr_q;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_of_verifla.sv
// Directed bench for uart_rx_of_verifla at BAUD_DIV=16; honours VERIFLA_RX_PARITY_EN.
module tb_uart_rx_of_verifla;
  localparam int unsigned Baud = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_of_verifla_if bus ();

  uart_rx_of_verifla #(
    .BAUD_DIV(Baud)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   ferr_cnt = 0;
  int   perr_cnt = 0;
  logic ready_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor samples 2 time units after each edge; stimulus runs on negedges.
  always @(posedge clk) begin
    #2;
    if (bus.rec_readyH === 1'b1 && ready_prev !== 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    ready_prev = bus.rec_readyH;
    if (bus.framing_err === 1'b1) ferr_cnt++;
    if (bus.parity_err === 1'b1) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (Baud) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_data(d);
`ifdef VERIFLA_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
  endtask

  int t_start;
  int base_rise;
  int base_ferr;
  int base_perr;

  initial begin
    rst    = 1'b1;
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_data", {24'd0, bus.rec_dataH}, 32'h00);
    check("reset_ready", {31'd0, bus.rec_readyH}, 32'd0);
    check("reset_ferr", {31'd0, bus.framing_err}, 32'd0);
    check("reset_perr", {31'd0, bus.parity_err}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0x01: rise expected 2 (synchronizer) + 153 cycles after the rx fall.
    base_rise = rise_cnt;
    t_start   = cyc;
    send_frame(8'h01, 1'b1);
    check("b01_latency", rise_cyc - t_start, 32'd155);
    check("b01_rises", rise_cnt - base_rise, 32'd1);
    check("b01_data", {24'd0, bus.rec_dataH}, 32'h01);
    check("b01_ready", {31'd0, bus.rec_readyH}, 32'd1);
    check("b01_errs", ferr_cnt + perr_cnt, 32'd0);

    // Back-to-back frames, no idle gap.
    base_rise = rise_cnt;
    send_frame(8'hA5, 1'b1);
    check("b2b_first", {24'd0, bus.rec_dataH}, 32'hA5);
    send_frame(8'h3C, 1'b1);
    check("b2b_second", {24'd0, bus.rec_dataH}, 32'h3C);
    check("b2b_rises", rise_cnt - base_rise, 32'd2);
    repeat (8) @(negedge clk);

    // 4-cycle glitch is rejected at the start-bit sample.
    base_rise = rise_cnt;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_data", {24'd0, bus.rec_dataH}, 32'h3C);
    check("glitch_ready", {31'd0, bus.rec_readyH}, 32'd1);
    check("glitch_rises", rise_cnt - base_rise, 32'd0);

    // Framing error followed by a 40-cycle break.
    base_rise = rise_cnt;
    base_ferr = ferr_cnt;
    send_data(8'h55);
`ifdef VERIFLA_RX_PARITY_EN
    send_bit(1'b0);
`endif
    send_bit(1'b0);
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_pulses", ferr_cnt - base_ferr, 32'd1);
    check("ferr_data", {24'd0, bus.rec_dataH}, 32'h3C);
    check("ferr_ready", {31'd0, bus.rec_readyH}, 32'd0);
    check("ferr_rises", rise_cnt - base_rise, 32'd0);
    send_frame(8'h01, 1'b1);
    check("post_ferr_data", {24'd0, bus.rec_dataH}, 32'h01);
    check("post_ferr_ready", {31'd0, bus.rec_readyH}, 32'd1);
    repeat (8) @(negedge clk);

    // Reset pulse in the middle of data bit 3 of 0xFF.
    base_rise = rise_cnt;
    base_ferr = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_data", {24'd0, bus.rec_dataH}, 32'h00);
    check("rst_ready", {31'd0, bus.rec_readyH}, 32'd0);
    check("rst_ferr", {31'd0, bus.framing_err}, 32'd0);
    repeat (12 * Baud) @(negedge clk);
    check("rst_rises", rise_cnt - base_rise, 32'd0);
    check("rst_no_ferr", ferr_cnt - base_ferr, 32'd0);
    check("rst_data_hold", {24'd0, bus.rec_dataH}, 32'h00);
    send_frame(8'h01, 1'b1);
    check("post_rst_data", {24'd0, bus.rec_dataH}, 32'h01);
    check("post_rst_rises", rise_cnt - base_rise, 32'd1);

`ifdef VERIFLA_RX_PARITY_EN
    repeat (8) @(negedge clk);
    base_rise = rise_cnt;
    base_perr = perr_cnt;
    send_data(8'h01);
    send_bit(1'b1);
    send_bit(1'b1);
    check("par_good_rises", rise_cnt - base_rise, 32'd1);
    check("par_good_perr", perr_cnt - base_perr, 32'd0);
    base_rise = rise_cnt;
    send_data(8'h01);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (4) @(negedge clk);
    check("par_bad_perr", perr_cnt - base_perr, 32'd1);
    check("par_bad_rises", rise_cnt - base_rise, 32'd0);
    check("par_bad_ready", {31'd0, bus.rec_readyH}, 32'd0);
`else
    base_perr = perr_cnt;
    send_frame(8'h80, 1'b1);
    check("np_data", {24'd0, bus.rec_dataH}, 32'h80);
    check("np_perr", perr_cnt - base_perr, 32'd0);
`endif
    check("total_perr_ferr", ferr_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_of_verifla.md
# uart_rx_of_verifla

Serial receive stage of the VeriFLA host link. It oversamples the asynchronous `rx` line from the host PC and deframes 8-bit asynchronous characters, LSB first, with 1 stop bit. Each good byte appears on `rec_dataH` together with the `rec_readyH` level. It sits directly upstream of the command decoder. That decoder edge-detects `rec_readyH` with its single-pulse cell, so this block must produce exactly one rising edge of `rec_readyH` per accepted byte.

## Interface
- `BAUD_DIV`, default 434: clk cycles per bit (50 MHz / 115200). Legal range is 4..65535.
- `HALF_DIV`, default `BAUD_DIV>>1`: cycles from start-bit detection to the start-bit sample.
- `clk`  in  1  Single system clock. All logic is on its rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `rx`  in  1  Asynchronous serial line. Idle level is 1.
- `rec_dataH`  out  8  Last accepted byte.
- `rec_readyH`  out  1  High from byte acceptance until the next start bit is validated.
- `framing_err`  out  1  One-cycle pulse when the stop bit is sampled as 0.
- `parity_err`  out  1  One-cycle pulse on parity mismatch. Constant 0 when parity is compiled out.

## Operation
- `rx` passes through a 2-FF synchronizer, giving `rx_s`. Both flops reset to 1.
- A 16-bit down-counter sets the bit timing. A 3-bit counter indexes the data bits. A shift register shifts right, so bit 0 enters first and ends in bit 0.
- State machine:
  - IDLE: when `rx_s`=0, load the counter with `HALF_DIV` and go to START. Call this cycle T0.
  - START: when the counter expires, sample `rx_s`.
    - If 1, it was a glitch: go to IDLE. No outputs change.
    - If 0, clear `rec_readyH`, load `BAUD_DIV`, and go to DATA.
  - DATA: sample one bit on each expiry, 8 bits total. After bit 7, go to PARITY if it is compiled in, otherwise go to STOP.
  - PARITY: sample the parity bit and latch the even-parity check result. Go to STOP.
  - STOP: sample the stop bit.
    - If 1 and parity is OK: load `rec_dataH` from the shift register, set `rec_readyH`, go to IDLE.
    - If 1 and parity failed: pulse `parity_err`, go to IDLE.
    - If 0: pulse `framing_err` and go to WAIT_HIGH. The parity result is ignored.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. A break condition therefore produces exactly one `framing_err`.
  - Any undefined state encoding goes to IDLE.
- On any error, `rec_dataH` and `rec_readyH` keep their previous values.
- Reset values: state IDLE, `rec_dataH`=0x00, `rec_readyH`=0, `framing_err`=0, `parity_err`=0, counters 0, shift register 0x00.
- `rst` asserted in any state, including mid-byte, aborts reception. The partial byte is discarded and nothing is emitted.

## Timing
- `rx_s` lags `rx` by 2 cycles. T0 is the first cycle IDLE sees `rx_s`=0.
- Sample points:
  - start bit at T0+`HALF_DIV`
  - data bit i at T0+`HALF_DIV`+(i+1)·`BAUD_DIV`
  - parity bit at T0+`HALF_DIV`+9·`BAUD_DIV`
  - stop bit at T0+`HALF_DIV`+9·`BAUD_DIV`, or +10·`BAUD_DIV` with parity
- Outputs are registered. `rec_readyH`, `rec_dataH` and the error pulses change on the cycle after the stop sample.
- `rec_readyH` falls at the start-bit sample of the next frame. Its low time is therefore 1 cycle at minimum, and it always goes low before the following byte rises.
- Back-to-back frames with no idle gap are required to work. Because the machine returns to IDLE at mid-stop bit, the next falling edge is caught.
- Tolerated baud mismatch is ±3% or better at `BAUD_DIV`≥16.

## Configuration
- Macro: `VERIFLA_RX_PARITY_EN`.
- Defined: the frame is 8E1. The state machine includes PARITY, and the parity bit must make the 9 sampled bits contain an even number of ones. On mismatch, `parity_err` pulses and the byte is dropped.
- Undefined: the frame is 8N1. PARITY is removed from the state machine and `parity_err` is tied to 0. The port list is the same in both builds.

## Test plan
All scenarios use `BAUD_DIV`=16 and start from reset released, with `rx` idle high.
- Send 0x01 (8N1): `rec_dataH`=0x01 and `rec_readyH` rises at T0+153. No error pulses.
- Send 0xA5 then 0x3C with no idle gap: `rec_readyH` shows two distinct rising edges. `rec_dataH` reads 0xA5, then 0x3C.
- Drive a 4-cycle low glitch on `rx`: the FSM returns to IDLE at T0+8, and `rec_readyH` and `rec_dataH` are unchanged.
- Send 0x55 with stop=0, then hold `rx` low for 40 cycles: `framing_err` gives a single pulse. `rec_dataH` keeps its previous value. The next valid 0x01 is received.
- Assert `rst` for 1 cycle during data bit 3 of 0xFF: all outputs return to reset values. No byte is emitted, and the following 0x01 is received correctly.
- With `VERIFLA_RX_PARITY_EN`: 0x01 with parity bit 1 is accepted. 0x01 with parity bit 0 gives a `parity_err` pulse and `rec_readyH` does not rise.
